// File: rtl/lsu_store_queue.sv
// Store buffer between the LSU and the data memory port: speculative queue (flushable) feeding an in-order committed queue.
// Optional STORE_QUEUE_FWD_CHECK_EN adds a page-offset hazard compare for loads.
module lsu_store_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    commit_i,
  output logic                    commit_ready_o,
  output logic                    no_st_pending_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic                    gnt_i,
`ifdef STORE_QUEUE_FWD_CHECK_EN
  input  logic [11:0]             page_offset_i,
  output logic                    page_offset_matches_o,
`endif
  output logic                    we_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BW-1:0]         be;
  } entry_t;

  entry_t        spec_q [DEPTH];
  entry_t        com_q  [DEPTH];
  logic [PW-1:0] spec_wptr, spec_rptr;
  logic [PW-1:0] com_wptr, com_rptr;
  logic [CW-1:0] spec_cnt, com_cnt;
  logic          push, commit, pop;

  assign ready_o         = (spec_cnt != FULL);
  assign commit_ready_o  = (com_cnt != FULL);
  assign req_o           = (com_cnt != '0);
  assign no_st_pending_o = (spec_cnt == '0) && (com_cnt == '0);
  assign we_o            = 1'b1;

  // Flush only suppresses the push; a same-cycle commit still moves its entry out.
  assign push   = valid_i & ready_o & ~flush_i;
  assign commit = commit_i & (spec_cnt != '0) & commit_ready_o;
  assign pop    = req_o & gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_wptr <= '0;
      spec_rptr <= '0;
      spec_cnt  <= '0;
      com_wptr  <= '0;
      com_rptr  <= '0;
      com_cnt   <= '0;
    end else begin
      if (flush_i) begin
        spec_wptr <= '0;
        spec_rptr <= '0;
        spec_cnt  <= '0;
      end else begin
        if (push)   spec_wptr <= spec_wptr + PW'(1);
        if (commit) spec_rptr <= spec_rptr + PW'(1);
        spec_cnt <= spec_cnt + CW'(push) - CW'(commit);
      end
      if (commit) com_wptr <= com_wptr + PW'(1);
      if (pop)    com_rptr <= com_rptr + PW'(1);
      com_cnt <= com_cnt + CW'(commit) - CW'(pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked solely by the counters.
  always_ff @(posedge clk_i) begin
    if (push)   spec_q[spec_wptr] <= '{addr: paddr_i, data: data_i, be: be_i};
    if (commit) com_q[com_wptr]   <= spec_q[spec_rptr];
  end

  assign addr_o  = com_q[com_rptr].addr;
  assign wdata_o = com_q[com_rptr].data;
  assign be_o    = com_q[com_rptr].be;

`ifdef STORE_QUEUE_FWD_CHECK_EN
  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < spec_cnt) &&
          (spec_q[spec_rptr + PW'(k)].addr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
      if ((CW'(k) < com_cnt) &&
          (com_q[com_rptr + PW'(k)].addr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
  end
`endif

  ast_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i |-> ready_o)
    else $warning("lsu_store_queue: store presented while full was dropped");

  ast_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> ((spec_cnt != '0) && commit_ready_o))
    else $error("lsu_store_queue: commit with empty spec queue or full commit queue");

endmodule
